uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 153 +++++++++++++++
 tb/tb_uart_tx.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter paced by an external baud level; each rising edge of baud is one bit boundary.
// States: IDLE wait for byte | SYNC wait first tick | START low bit | DATA LSB first | PARITY | STOP high bits.
module uart_tx #(
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 baud,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy
);

    localparam bit         LP_PAR_EN    = (PARITY_MODE == 1) || (PARITY_MODE == 2);
    localparam bit         LP_PAR_ODD   = (PARITY_MODE == 2);
    localparam logic [3:0] LP_LAST_BIT  = 4'(DATA_BITS - 1);
    localparam logic       LP_LAST_STOP = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               r_state;
    logic                 r_baud_q;
    logic [DATA_BITS-1:0] r_shift;
    logic [3:0]           r_bit_cnt;
    logic                 r_stop_cnt;
    logic                 r_parity;
    logic                 r_tx;
    logic                 r_busy;

    state_t               w_state_nxt;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic [3:0]           w_bit_cnt_nxt;
    logic                 w_stop_cnt_nxt;
    logic                 w_parity_nxt;
    logic                 w_tx_nxt;
    logic                 w_tick;
    logic                 w_accept;

    assign w_tick   = baud & ~r_baud_q;
    assign tx_ready = (r_state == S_IDLE);
    assign w_accept = tx_valid & tx_ready;
    assign tx       = r_tx;
    assign busy     = r_busy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_baud_q   <= 1'b0;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_parity   <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_baud_q   <= baud;
            r_shift    <= w_shift_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_stop_cnt <= w_stop_cnt_nxt;
            r_parity   <= w_parity_nxt;
            r_tx       <= w_tx_nxt;
            r_busy     <= (w_state_nxt != S_IDLE);
        end
    end

    // tx is registered from the value the next state will present, so the line never glitches.
    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_stop_cnt_nxt = r_stop_cnt;
        w_parity_nxt   = r_parity;
        w_tx_nxt       = r_tx;

        case (r_state)
            S_IDLE: begin
                w_tx_nxt = 1'b1;
                if (w_accept) begin
                    w_shift_nxt    = tx_data;
                    w_parity_nxt   = (^tx_data) ^ LP_PAR_ODD;
                    w_bit_cnt_nxt  = '0;
                    w_stop_cnt_nxt = 1'b0;
                    w_state_nxt    = S_SYNC;
                end
            end
            S_SYNC: begin
                if (w_tick) begin
                    w_tx_nxt    = 1'b0;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_tick) begin
                    w_tx_nxt      = r_shift[0];
                    w_bit_cnt_nxt = '0;
                    w_state_nxt   = S_DATA;
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    if (r_bit_cnt == LP_LAST_BIT) begin
                        w_stop_cnt_nxt = 1'b0;
                        if (LP_PAR_EN) begin
                            w_tx_nxt    = r_parity;
                            w_state_nxt = S_PARITY;
                        end else begin
                            w_tx_nxt    = 1'b1;
                            w_state_nxt = S_STOP;
                        end
                    end else begin
                        w_shift_nxt   = {1'b0, r_shift[DATA_BITS-1:1]};
                        w_tx_nxt      = r_shift[1];
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                if (w_tick) begin
                    w_tx_nxt       = 1'b1;
                    w_stop_cnt_nxt = 1'b0;
                    w_state_nxt    = S_STOP;
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    w_tx_nxt = 1'b1;
                    if (r_stop_cnt == LP_LAST_STOP) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_stop_cnt_nxt = r_stop_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_tx_nxt    = 1'b1;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four parameter sets share stimulus; a frame-level model predicts tx/ready/busy each cycle.
`timescale 1ns/1ps
module tb_uart_tx;

    localparam int NCFG = 4;
    localparam int CFG_DB   [NCFG] = '{8, 8, 8, 5};
    localparam int CFG_PAR  [NCFG] = '{0, 1, 2, 3};
    localparam int CFG_STOP [NCFG] = '{1, 1, 2, 2};

    logic            clk      = 1'b0;
    logic            rst_n    = 1'b0;
    logic            baud     = 1'b0;
    logic            tx_valid = 1'b0;
    logic [7:0]      tx_data  = 8'h00;
    logic [NCFG-1:0] tx_o;
    logic [NCFG-1:0] ready_o;
    logic [NCFG-1:0] busy_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_tx #(.DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_a (
        .clk(clk), .rst_n(rst_n), .baud(baud), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(ready_o[0]), .tx(tx_o[0]), .busy(busy_o[0]));
    uart_tx #(.DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) u_b (
        .clk(clk), .rst_n(rst_n), .baud(baud), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(ready_o[1]), .tx(tx_o[1]), .busy(busy_o[1]));
    uart_tx #(.DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(2)) u_c (
        .clk(clk), .rst_n(rst_n), .baud(baud), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(ready_o[2]), .tx(tx_o[2]), .busy(busy_o[2]));
    uart_tx #(.DATA_BITS(5), .PARITY_MODE(3), .STOP_BITS(2)) u_d (
        .clk(clk), .rst_n(rst_n), .baud(baud), .tx_data(tx_data[4:0]), .tx_valid(tx_valid),
        .tx_ready(ready_o[3]), .tx(tx_o[3]), .busy(busy_o[3]));

    // Baud level: fixed half-period of 4 cycles, or random half-periods, or frozen.
    logic baud_run = 1'b0;
    logic baud_rnd = 1'b0;
    int   baud_cnt = 0;
    always @(negedge clk) begin
        if (baud_run) begin
            if (baud_cnt <= 1) begin
                baud     = ~baud;
                baud_cnt = baud_rnd ? int'($urandom_range(1, 5)) : 4;
            end else begin
                baud_cnt = baud_cnt - 1;
            end
        end
    end

    // Reference model: each accepted byte becomes a list of line levels, one popped per tick.
    logic [15:0] m_frame [NCFG];
    int          m_left  [NCFG];
    bit          m_idle  [NCFG];
    bit          m_tx    [NCFG];
    bit          m_baud_q = 1'b0;
    bit          m_tick   = 1'b0;

    function automatic int build_frame(input int k, input logic [7:0] d, output logic [15:0] f);
        int n;
        bit p;
        n = 1;
        p = 1'b0;
        f = '0;
        for (int i = 0; i < CFG_DB[k]; i++) begin
            f[n] = d[i];
            p    = p ^ d[i];
            n++;
        end
        if (CFG_PAR[k] == 1 || CFG_PAR[k] == 2) begin
            f[n] = (CFG_PAR[k] == 2) ? ~p : p;
            n++;
        end
        for (int s = 0; s < ((CFG_STOP[k] == 2) ? 2 : 1); s++) begin
            f[n] = 1'b1;
            n++;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        bit tick_now;
        tick_now = baud && !m_baud_q;
        m_baud_q = rst_n ? baud : 1'b0;
        for (int k = 0; k < NCFG; k++) begin
            if (!rst_n) begin
                m_idle[k] = 1'b1;
                m_left[k] = 0;
                m_tx[k]   = 1'b1;
            end else if (m_idle[k]) begin
                m_tx[k] = 1'b1;
                if (tx_valid) begin
                    m_left[k] = build_frame(k, tx_data, m_frame[k]);
                    m_idle[k] = 1'b0;
                end
            end else if (tick_now) begin
                if (m_left[k] > 0) begin
                    m_tx[k]    = m_frame[k][0];
                    m_frame[k] = m_frame[k] >> 1;
                    m_left[k]  = m_left[k] - 1;
                end else begin
                    m_idle[k] = 1'b1;
                    m_tx[k]   = 1'b1;
                end
            end
        end
        m_tick = rst_n && tick_now;
    end

    logic chk_en = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < NCFG; k++) begin
                logic [2:0] act, exp;
                act = {tx_o[k], ready_o[k], busy_o[k]};
                exp = {m_tx[k], m_idle[k], ~m_idle[k]};
                n_vec++;
                if (act !== exp) begin
                    n_err++;
                    $display("FAIL cycle dut%0d t=%0t tx/ready/busy got %b want %b", k, $time, act, exp);
                end
            end
        end
    end

    // Per-tick log of line and ready levels for hand-computed frame checks.
    logic        logging = 1'b0;
    int          log_n   = 0;
    logic [31:0] log_tx  [NCFG];
    logic [31:0] log_rdy [NCFG];
    always @(negedge clk) begin
        if (logging && m_tick && log_n < 32) begin
            for (int k = 0; k < NCFG; k++) begin
                log_tx[k][log_n]  = tx_o[k];
                log_rdy[k][log_n] = ready_o[k];
            end
            log_n++;
        end
    end

    logic rdy_track  = 1'b0;
    int   rdy_run    = 0;
    int   rdy_max    = 0;
    int   rdy_pulses = 0;
    always @(negedge clk) begin
        if (rdy_track) begin
            if (ready_o[0]) begin
                rdy_run++;
            end else begin
                if (rdy_run > 0) begin
                    rdy_pulses++;
                    if (rdy_run > rdy_max) rdy_max = rdy_run;
                end
                rdy_run = 0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic wait_tick();
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!m_tick && guard < 200);
        if (!m_tick) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_tick: got timeout want baud tick");
        end
    endtask

    task automatic send_byte(input logic [7:0] d);
        wait_tick();
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        log_n    = 0;
        logging  = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < NCFG; k++) begin
            log_tx[k]  = '0;
            log_rdy[k] = '0;
        end
        tx_valid = 1'b1;
        repeat (3) @(negedge clk);
        tx_valid = 1'b0;
        rst_n    = 1'b1;
        chk_en   = 1'b1;
        check("reset tx", {31'd0, tx_o[0]}, 1);
        check("reset ready/busy", {30'd0, ready_o[0], busy_o[0]}, 2);
        baud_run = 1'b1;

        // 0xA5 on all four configurations
        send_byte(8'hA5);
        repeat (14) wait_tick();
        logging = 1'b0;
        check("A frame 0xA5", {22'd0, log_tx[0][9:0]}, 32'b1101001010);
        check("A idle after frame", {30'd0, log_tx[0][10], log_rdy[0][10]}, 3);
        check("A busy on last stop", {31'd0, log_rdy[0][9]}, 0);
        check("B even parity", {31'd0, log_tx[1][9]}, 0);
        check("C odd parity", {31'd0, log_tx[2][9]}, 1);
        check("C two stop bits", {30'd0, log_tx[2][11:10]}, 3);
        check("C ready after 2nd stop", {30'd0, log_rdy[2][12], log_rdy[2][11]}, 2);
        check("D 5-bit frame", {24'd0, log_tx[3][7:0]}, 32'b11001010);
        check("D ready timing", {30'd0, log_rdy[3][8], log_rdy[3][7]}, 2);

        // valid held high: 0x00 then 0xFF
        rdy_track = 1'b1;
        tx_data   = 8'h00;
        tx_valid  = 1'b1;
        repeat (14) wait_tick();
        tx_data = 8'hFF;
        repeat (30) wait_tick();
        tx_valid  = 1'b0;
        rdy_track = 1'b0;
        check("b2b ready width", rdy_max, 1);
        check("b2b ready pulses", {31'd0, rdy_pulses >= 3}, 1);
        repeat (14) wait_tick();

        // mid-frame data change to 0x3C
        send_byte(8'h81);
        repeat (3) wait_tick();
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        repeat (17) wait_tick();
        tx_valid = 1'b0;
        logging  = 1'b0;
        check("A frame 0x81 intact", {22'd0, log_tx[0][9:0]}, 32'b1100000010);
        check("A 0x3C after idle", {23'd0, log_tx[0][19:11]}, 32'b001111000);
        repeat (16) wait_tick();

        // reset during data bit 4
        send_byte(8'hC3);
        repeat (6) wait_tick();
        check("A busy before reset", {31'd0, busy_o[0]}, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("post-reset tx/ready/busy", {29'd0, tx_o[0], ready_o[0], busy_o[0]}, 6);
        send_byte(8'h5A);
        repeat (14) wait_tick();
        logging = 1'b0;
        check("A frame 0x5A after reset", {22'd0, log_tx[0][9:0]}, 32'b1010110100);

        // baud frozen during START
        send_byte(8'h0F);
        wait_tick();
        baud_run = 1'b0;
        repeat (1000) @(negedge clk);
        check("A start held", {30'd0, tx_o[0], busy_o[0]}, 1);
        baud_run = 1'b1;
        repeat (14) wait_tick();
        logging = 1'b0;
        check("A frame 0x0F after stall", {22'd0, log_tx[0][9:0]}, 32'b1000011110);

        // randomized traffic, baud spacing and occasional reset
        baud_rnd = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            tx_valid = ($urandom_range(0, 2) != 0);
            tx_data  = 8'($urandom);
            rst_n    = ($urandom_range(0, 499) != 0);
        end
        rst_n    = 1'b1;
        tx_valid = 1'b0;
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
